// File: rtl/integrator_antiwindup.sv
// Discrete-time integrator with saturated output and back-calculation
// anti-windup. The accumulator is kept wider than the output so it can
// overshoot the limits by a bounded amount; the dead-zone (acc - sat(acc))
// is fed back, scaled by 2^-KAW_SHIFT, to pull it back towards the band.
//
// Handshake: a sample on e is consumed on any rising edge where
// enable & in_valid & ~clear is high; there is no backpressure. out_valid is a
// one-cycle strobe two edges later, marking y/y_dz/sat_* as the result of
// exactly one consumed sample. Outputs are refreshed every cycle regardless.
module integrator_antiwindup #(
  parameter int N_BIT       = 32,
  parameter int GUARD       = 4,
  parameter int UPPER_LIMIT = 100,
  parameter int LOWER_LIMIT = -100,
  parameter int KAW_SHIFT   = 0,
  parameter int INIT_VALUE  = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic signed [N_BIT-1:0] e,
  output logic                    out_valid,
  output logic signed [N_BIT-1:0] y,
  output logic signed [N_BIT-1:0] y_dz,
  output logic                    sat_hi,
  output logic                    sat_lo
);

  localparam int A  = N_BIT + GUARD;
  // Sum width: acc, sample and the (A+1)-bit dead-zone term can never
  // overflow this, so clamping afterwards is exact.
  localparam int SW = A + 3;

  localparam longint N_HI = (longint'(1) <<< (N_BIT - 1)) - 1;
  localparam longint N_LO = -(longint'(1) <<< (N_BIT - 1));
  localparam longint A_HI = (longint'(1) <<< (A - 1)) - 1;
  localparam longint A_LO = -(longint'(1) <<< (A - 1));

  // Elaboration-time parameter sanity checks.
  if (GUARD < 1) begin : g_bad_guard
    $error("integrator_antiwindup: GUARD must be at least 1");
  end
  if (longint'(UPPER_LIMIT) > N_HI || longint'(LOWER_LIMIT) < N_LO) begin : g_bad_range
    $error("integrator_antiwindup: limits not representable in N_BIT");
  end
  if (LOWER_LIMIT >= UPPER_LIMIT) begin : g_bad_order
    $error("integrator_antiwindup: LOWER_LIMIT must be below UPPER_LIMIT");
  end
  if (KAW_SHIFT < 0 || KAW_SHIFT > A - 1) begin : g_bad_kaw
    $error("integrator_antiwindup: KAW_SHIFT out of range 0..A-1");
  end
  if (longint'(INIT_VALUE) > A_HI || longint'(INIT_VALUE) < A_LO) begin : g_bad_init
    $error("integrator_antiwindup: INIT_VALUE not representable in accumulator");
  end

  localparam logic signed [A-1:0]  UP_A    = A'(UPPER_LIMIT);
  localparam logic signed [A-1:0]  LO_A    = A'(LOWER_LIMIT);
  localparam logic signed [A-1:0]  INIT_A  = A'(INIT_VALUE);
  localparam logic signed [A-1:0]  ACC_MAX = {1'b0, {(A-1){1'b1}}};
  localparam logic signed [A-1:0]  ACC_MIN = {1'b1, {(A-1){1'b0}}};
  localparam logic signed [SW-1:0] SUM_MAX = SW'(ACC_MAX);
  localparam logic signed [SW-1:0] SUM_MIN = SW'(ACC_MIN);
  localparam logic signed [N_BIT-1:0] Y_MAX = {1'b0, {(N_BIT-1){1'b1}}};
  localparam logic signed [N_BIT-1:0] Y_MIN = {1'b1, {(N_BIT-1){1'b0}}};
  localparam logic signed [A:0]    DZ_MAX  = (A+1)'(Y_MAX);
  localparam logic signed [A:0]    DZ_MIN  = (A+1)'(Y_MIN);

  logic signed [A-1:0]     r_acc;
  logic                    r_acc_vld;

  logic                    w_accept;
  logic                    w_gt;
  logic                    w_lt;
  logic signed [A-1:0]     w_sat;
  logic signed [A:0]       w_dz;
  logic signed [A:0]       w_dz_sh;
  logic signed [SW-1:0]    w_sum;
  logic signed [A-1:0]     w_acc_next;
  logic signed [N_BIT-1:0] w_dz_n;

  assign w_accept = enable & in_valid & ~clear;

  // Saturation of the current accumulator and its dead-zone remainder.
  always_comb begin
    w_gt  = (r_acc > UP_A);
    w_lt  = (r_acc < LO_A);
    w_sat = r_acc;
    if (w_gt) begin
      w_sat = UP_A;
    end else if (w_lt) begin
      w_sat = LO_A;
    end
    // One extra bit keeps acc - sat exact even for negative upper limits.
    w_dz    = (A+1)'(r_acc) - (A+1)'(w_sat);
    w_dz_sh = w_dz >>> KAW_SHIFT;
  end

  // Next accumulator value: integrate, subtract feedback, clamp (never wrap).
  always_comb begin
    w_sum      = SW'(r_acc) + SW'(e) - SW'(w_dz_sh);
    w_acc_next = w_sum[A-1:0];
    if (w_sum > SUM_MAX) begin
      w_acc_next = ACC_MAX;
    end else if (w_sum < SUM_MIN) begin
      w_acc_next = ACC_MIN;
    end
  end

  // Dead-zone clamped into the output word.
  always_comb begin
    w_dz_n = w_dz[N_BIT-1:0];
    if (w_dz > DZ_MAX) begin
      w_dz_n = Y_MAX;
    end else if (w_dz < DZ_MIN) begin
      w_dz_n = Y_MIN;
    end
  end

  // Accumulator and accept-pipeline register; clear beats a same-cycle sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_acc     <= INIT_A;
      r_acc_vld <= 1'b0;
    end else begin
      if (clear) begin
        r_acc <= INIT_A;
      end else if (w_accept) begin
        r_acc <= w_acc_next;
      end
      r_acc_vld <= w_accept;
    end
  end

  // Output stage, reloaded from the current accumulator every cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      y_dz      <= '0;
      sat_hi    <= 1'b0;
      sat_lo    <= 1'b0;
    end else begin
      out_valid <= r_acc_vld;
      y         <= w_sat[N_BIT-1:0];
      y_dz      <= w_dz_n;
      sat_hi    <= w_gt;
      sat_lo    <= w_lt;
    end
  end

endmodule

// File: tb/tb_integrator_antiwindup.sv
// Directed bench for integrator_antiwindup: three instances that differ only
// in KAW_SHIFT (0, 2, 19) share the stimulus; one is selected for checking.
module tb_integrator_antiwindup;

  localparam int N = 16;
  localparam int W = 2 * N + 2;
  localparam int KAWS [3] = '{0, 2, 19};

  // Clock and reset.
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                reset_n;
  logic                enable;
  logic                clear;
  logic                in_valid;
  logic signed [N-1:0] e_in;

  logic                ov    [3];
  logic signed [N-1:0] y_o   [3];
  logic signed [N-1:0] ydz_o [3];
  logic                hi_o  [3];
  logic                lo_o  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    integrator_antiwindup #(
      .N_BIT(N), .GUARD(4), .UPPER_LIMIT(100), .LOWER_LIMIT(-100),
      .KAW_SHIFT(KAWS[g]), .INIT_VALUE(0)
    ) u_dut (
      .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
      .in_valid(in_valid), .e(e_in),
      .out_valid(ov[g]), .y(y_o[g]), .y_dz(ydz_o[g]),
      .sat_hi(hi_o[g]), .sat_lo(lo_o[g])
    );
  end

  int                  sel = 0;
  logic                m_ov;
  logic signed [N-1:0] m_y;
  logic signed [N-1:0] m_ydz;
  logic                m_hi;
  logic                m_lo;

  always_comb begin
    m_ov  = ov[sel];
    m_y   = y_o[sel];
    m_ydz = ydz_o[sel];
    m_hi  = hi_o[sel];
    m_lo  = lo_o[sel];
  end

  int    n_checks = 0;
  int    n_errors = 0;
  string cur      = "init";
  bit    mon_en   = 1'b0;
  logic [W-1:0] exp_q [$];

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver tasks: called at a falling edge, return at the next falling edge.
  task automatic send(input int v);
    in_valid = 1'b1;
    e_in     = N'(v);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    e_in     = '0;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    clear    = 1'b1;
    @(negedge clock);
    clear    = 1'b0;
    @(negedge clock);
  endtask

  task automatic expect_out(input int ey, input int edz, input bit ehi, input bit elo);
    exp_q.push_back({N'(ey), N'(edz), ehi, elo});
  endtask

  // Scoreboard: every out_valid strobe of the selected instance pops one entry.
  always @(negedge clock) begin
    logic [W-1:0] x;
    if (mon_en && m_ov === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk({cur, "_unexpected_valid"}, m_ov, 0);
      end else begin
        x = exp_q.pop_front();
        chk({cur, "_y"},    m_y,   $signed(x[W-1:N+2]));
        chk({cur, "_ydz"},  m_ydz, $signed(x[N+1:2]));
        chk({cur, "_hi"},   m_hi,  x[1]);
        chk({cur, "_lo"},   m_lo,  x[0]);
      end
    end
  end

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    e_in     = '0;
    repeat (2) @(negedge clock);

    // Outputs held at zero during reset.
    cur = "reset";
    for (int g = 0; g < 3; g++) begin
      chk("reset_y",   y_o[g],   0);
      chk("reset_ydz", ydz_o[g], 0);
      chk("reset_ov",  ov[g],    0);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_y",   m_y,   0);
    chk("idle_ydz", m_ydz, 0);
    chk("idle_ov",  m_ov,  0);
    chk("idle_hi",  m_hi,  0);

    // KAW_SHIFT=0: linear ramp, latency two edges.
    enable = 1'b1;
    mon_en = 1'b1;
    cur    = "ramp10";
    for (int i = 1; i <= 5; i++) expect_out(10 * i, 0, 1'b0, 1'b0);
    send(10);
    chk("ramp10_latency", m_ov, 0);
    for (int i = 0; i < 4; i++) send(10);
    idle(3);
    chk("ramp10_drain", exp_q.size(), 0);

    // KAW_SHIFT=0: saturation with no windup.
    do_clear();
    cur = "sat30";
    expect_out(30, 0, 0, 0);
    expect_out(60, 0, 0, 0);
    expect_out(90, 0, 0, 0);
    expect_out(100, 20, 1, 0);
    expect_out(100, 30, 1, 0);
    expect_out(100, 30, 1, 0);
    expect_out(90, 0, 0, 0);
    for (int i = 0; i < 6; i++) send(30);
    send(-10);
    idle(3);
    chk("sat30_drain", exp_q.size(), 0);

    // KAW_SHIFT=2: bounded overshoot (120 -> 145 -> 164).
    sel = 1;
    do_clear();
    cur = "kaw2";
    expect_out(100, 20, 1, 0);
    expect_out(100, 45, 1, 0);
    expect_out(100, 64, 1, 0);
    send(120);
    send(30);
    send(30);
    idle(3);
    chk("kaw2_drain", exp_q.size(), 0);

    // KAW_SHIFT=19: accumulator clamps at the A-bit extremes, never wraps.
    sel = 2;
    do_clear();
    cur = "kaw19_pos";
    expect_out(100, 32667, 1, 0);
    for (int i = 1; i < 20; i++) expect_out(100, 32767, 1, 0);
    for (int i = 0; i < 20; i++) send(32767);
    idle(3);
    chk("kaw19_pos_drain", exp_q.size(), 0);
    mon_en = 1'b0;
    for (int i = 0; i < 40; i++) send(-32768);
    idle(3);
    chk("kaw19_neg_y",   m_y,   -100);
    chk("kaw19_neg_ydz", m_ydz, -32768);
    chk("kaw19_neg_lo",  m_lo,  1);
    chk("kaw19_neg_hi",  m_hi,  0);

    // enable low: samples ignored, output holds, no strobe.
    sel    = 0;
    mon_en = 1'b1;
    cur    = "hold";
    enable = 1'b0;
    for (int i = 0; i < 3; i++) send(40);
    idle(2);
    chk("hold_y", m_y, -100);
    chk("hold_ov", m_ov, 0);
    enable = 1'b1;

    // Clear: earlier sample still emerges, same-cycle sample dropped.
    do_clear();
    mon_en = 1'b0;
    send(20);
    clear = 1'b1;
    send(50);
    chk("clr_prev_ov", m_ov, 1);
    chk("clr_prev_y",  m_y,  20);
    clear = 1'b0;
    idle(1);
    chk("clr_ov",  m_ov,  0);
    chk("clr_y",   m_y,   0);
    chk("clr_ydz", m_ydz, 0);
    idle(1);
    chk("clr_ov2", m_ov, 0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) send(10);
    @(posedge clock);
    #2;
    chk("pre_rst_ov", m_ov, 1);
    reset_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("async_rst_ov",  ov[g],    0);
      chk("async_rst_y",   y_o[g],   0);
      chk("async_rst_ydz", ydz_o[g], 0);
      chk("async_rst_hi",  hi_o[g],  0);
      chk("async_rst_lo",  lo_o[g],  0);
    end
    in_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    idle(3);
    chk("post_rst_y",  m_y,  0);
    chk("post_rst_ov", m_ov, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
